// File: rtl/dm_bus_arbiter_pkg.sv
// Shared types and constants for the debug-module bus arbiter.
package dm_bus_arbiter_pkg;

  localparam int unsigned BUS_AW = 20;
  localparam int unsigned BUS_DW = 32;

  // Debug-module bus address map seen by the harts.
  localparam logic [BUS_AW-1:0] DM_ROM_BASE    = 20'h00000;
  localparam logic [BUS_AW-1:0] DM_REQUEST     = 20'h00100;
  localparam logic [BUS_AW-1:0] DM_DATA0       = 20'h00380;
  localparam logic [BUS_AW-1:0] DM_DATA1       = 20'h00384;
  localparam logic [BUS_AW-1:0] DM_CORE_HALT   = 20'h00390;
  localparam logic [BUS_AW-1:0] DM_CORE_RESUME = 20'h00394;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              write;
    logic [BUS_AW-1:0] addr;
    logic [BUS_DW-1:0] wdata;
  } bus_req_t;

  // Grant index width; a single hart still gets a 1-bit index.
  function automatic int unsigned grant_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dm_rr_picker.sv
// Combinational round-robin priority encoder: first set request at or above ptr, wrapping.
module dm_rr_picker
  import dm_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_HART = 2,
  parameter int unsigned GW       = grant_width(NUM_HART)
) (
  input  logic [NUM_HART-1:0] req,
  input  logic [GW-1:0]       ptr,
  output logic [GW-1:0]       gnt_idx,
  output logic                any
);

  // Scan offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    int unsigned idx;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int i = int'(NUM_HART) - 1; i >= 0; i--) begin
      idx = (32'(ptr) + 32'(i)) % NUM_HART;
      if (req[idx]) begin
        gnt_idx = GW'(idx);
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dm_bus_arbiter.sv
// Round-robin, non-pipelined arbiter sharing the debug-module bus port between harts.
module dm_bus_arbiter
  import dm_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_HART = 2,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_HART-1:0]        hart_valid,
  input  logic [NUM_HART-1:0]        hart_write,
  input  logic [NUM_HART*BUS_AW-1:0] hart_addr,
  input  logic [NUM_HART*BUS_DW-1:0] hart_wdata,
  output logic [NUM_HART-1:0]        hart_ready,
  output logic [BUS_DW-1:0]          hart_rdata,
  output logic                       hart_err,
  output logic                       dm_valid,
  output logic                       dm_write,
  output logic [BUS_AW-1:0]          dm_addr,
  output logic [BUS_DW-1:0]          dm_wdata,
  input  logic                       dm_ready,
  input  logic [BUS_DW-1:0]          dm_rdata
);

  localparam int unsigned GW = grant_width(NUM_HART);
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  arb_state_t          state_q, state_d;
  logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [TW-1:0]       timer_q, timer_d;
  bus_req_t            req_q, req_d;
  logic [BUS_DW-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [NUM_HART-1:0] ready_q, ready_d;
  logic                dm_valid_q, dm_valid_d;

  logic [GW-1:0]       pick_idx;
  logic                pick_any;
  bus_req_t            hart_req [NUM_HART];
  bus_req_t            sel_req;
  logic [NUM_HART-1:0] grant_onehot;

  // Unpack the flat per-hart request buses.
  for (genvar g = 0; g < NUM_HART; g++) begin : g_unpack
    assign hart_req[g] = '{write: hart_write[g],
                           addr:  hart_addr[g*BUS_AW +: BUS_AW],
                           wdata: hart_wdata[g*BUS_DW +: BUS_DW]};
  end

  dm_rr_picker #(
    .NUM_HART (NUM_HART),
    .GW       (GW)
  ) u_picker (
    .req     (hart_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Request fields of the hart the picker selected.
  always_comb begin
    sel_req = '0;
    for (int unsigned i = 0; i < NUM_HART; i++) begin
      if (pick_idx == GW'(i)) sel_req = hart_req[i];
    end
  end

  // One-hot decode of the current grant for the completion pulse.
  always_comb begin
    grant_onehot = '0;
    for (int unsigned i = 0; i < NUM_HART; i++) begin
      grant_onehot[i] = (grant_q == GW'(i));
    end
  end

  // Next-state and next-register values; everything holds unless a state acts.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    timer_d    = timer_q;
    req_d      = req_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    ready_d    = '0;
    dm_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d    = pick_idx;
          req_d      = sel_req;
          timer_d    = '0;
          dm_valid_d = 1'b1;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        timer_d = timer_q + TW'(1);
        if (dm_ready) begin
          rdata_d = req_q.write ? '0 : dm_rdata;
          err_d   = 1'b0;
          ready_d = grant_onehot;
          state_d = ST_RESP;
        end else if ((TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1))) begin
          // Valid drops before the DM ever acks, so no stale ready can follow.
          rdata_d = '0;
          err_d   = 1'b1;
          ready_d = grant_onehot;
          state_d = ST_RESP;
        end else begin
          dm_valid_d = 1'b1;
        end
      end
      ST_RESP: begin
        rr_ptr_d = GW'((32'(grant_q) + 32'd1) % NUM_HART);
        timer_d  = '0;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; async reset kills any in-flight access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      timer_q    <= '0;
      req_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      ready_q    <= '0;
      dm_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      timer_q    <= timer_d;
      req_q      <= req_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      dm_valid_q <= dm_valid_d;
    end
  end

  assign hart_ready = ready_q;
  assign hart_rdata = rdata_q;
  assign hart_err   = err_q;
  assign dm_valid   = dm_valid_q;
  assign dm_write   = req_q.write;
  assign dm_addr    = req_q.addr;
  assign dm_wdata   = req_q.wdata;

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Scoreboard bench for dm_bus_arbiter with a randomized hart driver and a DM bus model.
module tb_dm_bus_arbiter;
  import dm_bus_arbiter_pkg::*;

  localparam int NH = 2;
  localparam int TO = 4;

  logic            clk;
  logic            resetn;
  logic [NH-1:0]   hart_valid, hart_write;
  logic [NH*20-1:0] hart_addr;
  logic [NH*32-1:0] hart_wdata;
  logic [NH-1:0]   hart_ready;
  logic [31:0]     hart_rdata;
  logic            hart_err;
  logic            dm_valid, dm_write, dm_ready;
  logic [19:0]     dm_addr;
  logic [31:0]     dm_wdata, dm_rdata;

  dm_bus_arbiter #(.NUM_HART(NH), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .hart_valid(hart_valid), .hart_write(hart_write),
    .hart_addr(hart_addr), .hart_wdata(hart_wdata),
    .hart_ready(hart_ready), .hart_rdata(hart_rdata), .hart_err(hart_err),
    .dm_valid(dm_valid), .dm_write(dm_write), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          hart;
    logic [31:0] rdata;
    logic        err;
    int          vcyc;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          force_delay = -1;
  logic [31:0] force_data = 32'h0;
  int          cur_delay = 0;
  logic [31:0] cur_rdata = 32'h0;
  bit          run_en = 1'b0;
  int          gap [NH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // DM bus slave: acks after a chosen delay, clears ready on the match, may never ack.
  initial begin
    int cnt;
    cnt = 0;
    dm_ready = 1'b0;
    dm_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (dm_ready) begin
        dm_ready = 1'b0;
        cnt = 0;
      end else if (!dm_valid) begin
        cnt = 0;
      end else begin
        if (cnt == 0) begin
          if (force_delay >= 0) begin
            cur_delay = force_delay;
            cur_rdata = force_data;
          end else begin
            cur_delay = ($urandom_range(0, 7) == 0) ? 100 : int'($urandom_range(1, 3));
            cur_rdata = $urandom;
          end
        end
        cnt++;
        if (cnt == cur_delay + 1) begin
          dm_ready = 1'b1;
          dm_rdata = cur_rdata;
        end
      end
      if (!dm_ready) dm_rdata = $urandom;
    end
  end

  // Reference: round-robin over the requests visible in the last idle cycle.
  initial begin
    int          ref_ptr, g;
    logic [NH-1:0] snap;
    bit          prev_idle, prev_dv, rise, found, to;
    logic [19:0] l_addr;
    logic [31:0] l_wdata;
    logic        l_write;
    exp_t        e;
    ref_ptr = 0; snap = '0; prev_idle = 0; prev_dv = 0;
    l_addr = '0; l_wdata = '0; l_write = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        ref_ptr = 0; snap = '0; prev_idle = 0; prev_dv = 0;
      end else begin
        rise = dm_valid && !prev_dv;
        if (prev_idle) chk("grant_latency", 32'(rise), 32'(|snap));
        if (rise) begin
          g = ref_ptr;
          found = 0;
          for (int k = 0; k < NH; k++) begin
            if (!found && snap[(ref_ptr + k) % NH]) begin
              g = (ref_ptr + k) % NH;
              found = 1;
            end
          end
          l_write = hart_write[g];
          l_addr  = hart_addr[g*20 +: 20];
          l_wdata = hart_wdata[g*32 +: 32];
          chk("req_write", 32'(dm_write), 32'(l_write));
          chk("req_addr", 32'(dm_addr), 32'(l_addr));
          chk("req_wdata", dm_wdata, l_wdata);
          to = (cur_delay >= TO);
          e.hart  = g;
          e.err   = to;
          e.rdata = (l_write || to) ? 32'h0 : cur_rdata;
          e.vcyc  = to ? TO : cur_delay + 1;
          sb.push_back(e);
          ref_ptr = (g + 1) % NH;
        end else if (dm_valid) begin
          chk("busy_stable_addr", 32'(dm_addr), 32'(l_addr));
          chk("busy_stable_wdata", dm_wdata, l_wdata);
        end
        prev_idle = !dm_valid && (hart_ready == '0);
        prev_dv   = dm_valid;
        snap      = hart_valid;
      end
    end
  end

  // Monitor: every completion pulse is matched against the oldest expectation.
  initial begin
    int   vcnt;
    exp_t e;
    vcnt = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        sb.delete();
        vcnt = 0;
      end else begin
        if (dm_valid) vcnt++;
        if (hart_ready != '0) begin
          if (sb.size() == 0) begin
            chk("unexpected_ready", 32'(hart_ready), 32'h0);
          end else begin
            e = sb.pop_front();
            chk("resp_hart", 32'(hart_ready), 32'(1) << e.hart);
            chk("resp_rdata", hart_rdata, e.rdata);
            chk("resp_err", 32'(hart_err), 32'(e.err));
            chk("resp_valid_cycles", 32'(vcnt), 32'(e.vcyc));
          end
          vcnt = 0;
        end
      end
    end
  end

  task automatic new_req(input int i);
    hart_valid[i] = 1'b1;
    hart_write[i] = 1'($urandom);
    case ($urandom_range(0, 3))
      0: hart_addr[i*20 +: 20] = DM_DATA0;
      1: hart_addr[i*20 +: 20] = DM_DATA1;
      2: hart_addr[i*20 +: 20] = DM_CORE_HALT;
      default: hart_addr[i*20 +: 20] = 20'($urandom);
    endcase
    hart_wdata[i*32 +: 32] = $urandom;
  endtask

  // Per-cycle random hart behaviour; requests hold until their completion pulse.
  task automatic drive_cycle();
    for (int i = 0; i < NH; i++) begin
      if (hart_valid[i]) begin
        if (hart_ready[i]) begin
          if (run_en && $urandom_range(0, 1) == 1) new_req(i);
          else begin
            hart_valid[i] = 1'b0;
            gap[i] = int'($urandom_range(0, 3));
          end
        end
      end else if (gap[i] > 0) begin
        gap[i]--;
      end else if (run_en && $urandom_range(0, 2) == 0) begin
        new_req(i);
      end
    end
  endtask

  task automatic wait_ready(output logic [NH-1:0] r);
    int k;
    k = 0;
    r = '0;
    while (k < 30 && r == '0) begin
      @(posedge clk); #1;
      k++;
      r = hart_ready;
    end
  endtask

  initial begin
    logic [NH-1:0] r;
    int n, k;
    resetn = 1'b0;
    hart_valid = '0; hart_write = '0; hart_addr = '0; hart_wdata = '0;
    for (int i = 0; i < NH; i++) gap[i] = 0;
    repeat (3) @(posedge clk);
    #3 resetn = 1'b1;
    @(posedge clk); #1;
    chk("rst_hart_ready", 32'(hart_ready), 32'h0);
    chk("rst_hart_rdata", hart_rdata, 32'h0);
    chk("rst_hart_err", 32'(hart_err), 32'h0);
    chk("rst_dm_valid", 32'(dm_valid), 32'h0);
    chk("rst_dm_write", 32'(dm_write), 32'h0);
    chk("rst_dm_addr", 32'(dm_addr), 32'h0);
    chk("rst_dm_wdata", dm_wdata, 32'h0);

    // Single read from ROM, DM acks one cycle after valid.
    force_delay = 1; force_data = 32'h0010006F;
    hart_valid = 2'b01; hart_write = 2'b00; hart_addr[19:0] = DM_ROM_BASE;
    @(posedge clk); #1;
    chk("single_dm_valid_c1", 32'(dm_valid), 32'h1);
    @(posedge clk); #1;
    chk("single_ready_c2", 32'(hart_ready), 32'h0);
    @(posedge clk); #1;
    chk("single_ready_c3", 32'(hart_ready), 32'h1);
    chk("single_rdata", hart_rdata, 32'h0010006F);
    chk("single_err", 32'(hart_err), 32'h0);
    hart_valid = '0;
    @(posedge clk); #1;

    // Timeout: DM never acks.
    force_delay = 100;
    hart_valid = 2'b10; hart_write = 2'b10;
    hart_addr[39:20] = DM_CORE_HALT; hart_wdata[63:32] = 32'h1;
    n = 0; k = 0;
    while (k < 20 && hart_ready == '0) begin
      @(posedge clk); #1;
      k++;
      if (dm_valid) n++;
    end
    chk("timeout_valid_cycles", 32'(n), 32'(TO));
    chk("timeout_ready", 32'(hart_ready), 32'h2);
    chk("timeout_err", 32'(hart_err), 32'h1);
    chk("timeout_rdata", hart_rdata, 32'h0);
    hart_valid = '0;
    @(posedge clk); #1;

    // Contention: hart0 writes DATA0, hart1 reads DATA1.
    force_delay = 1; force_data = 32'hCAFE0001;
    hart_valid = 2'b11; hart_write = 2'b01;
    hart_addr = {DM_DATA1, DM_DATA0}; hart_wdata = {32'h0, 32'h12345678};
    wait_ready(r);
    chk("contend_first", 32'(r), 32'h1);
    hart_valid[0] = 1'b0;
    wait_ready(r);
    chk("contend_second", 32'(r), 32'h2);
    chk("contend_rdata", hart_rdata, 32'hCAFE0001);
    hart_valid = '0;
    @(posedge clk); #1;

    // Fairness: both harts request continuously.
    hart_valid = 2'b11;
    for (int t = 0; t < 8; t++) begin
      wait_ready(r);
      chk("fair_order", 32'(r), (t % 2 == 0) ? 32'h1 : 32'h2);
    end
    hart_valid = '0;
    force_delay = -1;

    // Random traffic.
    run_en = 1'b1;
    repeat (2000) begin
      @(posedge clk); #1;
      drive_cycle();
    end

    // Asynchronous reset in the middle of a BUSY access.
    k = 0;
    while (!dm_valid && k < 100) begin
      @(posedge clk); #1;
      drive_cycle();
      k++;
    end
    chk("rst_found_busy", 32'(dm_valid), 32'h1);
    #2 resetn = 1'b0;
    #1;
    chk("rst_async_dm_valid", 32'(dm_valid), 32'h0);
    chk("rst_async_ready", 32'(hart_ready), 32'h0);
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_ready", 32'(hart_ready), 32'h0);
    drive_cycle();
    repeat (1500) begin
      @(posedge clk); #1;
      drive_cycle();
    end

    // Drain outstanding traffic.
    run_en = 1'b0;
    k = 0;
    while (k < 300 && (hart_valid != '0 || dm_valid || hart_ready != '0)) begin
      @(posedge clk); #1;
      drive_cycle();
      k++;
    end
    chk("drain_done", 32'(k < 300), 32'h1);
    repeat (2) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
